rv32_data_path: RTL and testbench



---
 rtl/rv32_pkg.sv | 99 +++++++++
 rtl/rv32_data_path_if.sv | 13 +
 rtl/rv32_dmem.sv | 35 +++
 rtl/rv32_regfile.sv | 32 +++
 rtl/rv32_data_path.sv | 220 ++++++++++++++++++++++
 tb/tb_rv32_data_path.sv | 212 +++++++++++++++++++++
 6 files changed

// File: rtl/rv32_pkg.sv
// Shared definitions for the rv32_data_path core.
// Holds opcode and funct3/funct7 encodings, the decoded-control enums, the
// packed control word and the ALU-operation decode helper.
package rv32_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RF_DEPTH = 32;

  // Major opcodes
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  // ALU funct3
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  // Memory access width and branch conditions
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;

  // funct7 selecting sub / sra
  localparam logic [6:0] F7_ALT = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA
  } alu_op_e;

  typedef enum logic [1:0] {
    WB_ALU, WB_MEM, WB_PC4, WB_IMM
  } wb_sel_e;

  typedef enum logic [2:0] {
    IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
  } imm_sel_e;

  typedef struct packed {
    logic     reg_we;
    logic     mem_we;
    logic     alu_a_pc;
    logic     alu_b_imm;
    alu_op_e  alu_op;
    imm_sel_e imm_sel;
    wb_sel_e  wb_sel;
    logic     branch;
    logic     jal;
    logic     jalr;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{
    reg_we:    1'b0,
    mem_we:    1'b0,
    alu_a_pc:  1'b0,
    alu_b_imm: 1'b0,
    alu_op:    ALU_ADD,
    imm_sel:   IMM_I,
    wb_sel:    WB_ALU,
    branch:    1'b0,
    jal:       1'b0,
    jalr:      1'b0
  };

  // ALU op from funct3; sub only exists in register form, sra in both
  function automatic alu_op_e alu_op_decode(input logic [2:0] f3,
                                            input logic       alt,
                                            input logic       is_reg);
    alu_op_e op;
    op = ALU_ADD;
    case (f3)
      F3_ADD_SUB: op = (alt && is_reg) ? ALU_SUB : ALU_ADD;
      F3_SLL:     op = ALU_SLL;
      F3_SLT:     op = ALU_SLT;
      F3_SLTU:    op = ALU_SLTU;
      F3_XOR:     op = ALU_XOR;
      F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:      op = ALU_OR;
      F3_AND:     op = ALU_AND;
      default:    op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv32_data_path_if.sv
// Data-memory bus between the core and its data RAM.
// master: addr, wdata, we out / rdata in.  slave: the reverse.
interface rv32_data_path_if;
  import rv32_pkg::*;

  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic            we;
  logic [XLEN-1:0] rdata;

  modport master (output addr, output wdata, output we, input rdata);
  modport slave  (input addr, input wdata, input we, output rdata);
endinterface

// File: rtl/rv32_dmem.sv
// Word-addressed data RAM with combinational read and posedge write.
// Ports: clk, bus (slave side of rv32_data_path_if).
// Byte offset bits are ignored and the word index wraps modulo DEPTH.
// Contents are never cleared by reset; they start all zero.
module rv32_dmem
  import rv32_pkg::*;
#(
  parameter int unsigned DEPTH     = 32,
  parameter string       INIT_FILE = ""
) (
  input logic              clk,
  rv32_data_path_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [XLEN-1:0] ram [0:DEPTH-1];
  logic [AW-1:0]   index;
  logic            unused_addr_bits;

  // Power-on image
  initial begin
    for (int i = 0; i < int'(DEPTH); i++) ram[i] = '0;
  end

  assign index            = bus.addr[AW+1:2];
  assign unused_addr_bits = ^{bus.addr[XLEN-1:AW+2], bus.addr[1:0]};

  always_ff @(posedge clk) begin
    if (bus.we) ram[index] <= bus.wdata;
  end

  assign bus.rdata = ram[index];

endmodule

// File: rtl/rv32_regfile.sv
// 32x32 register file: two combinational read ports, one write port.
// Ports: clk, rst (sync active-low, clears all entries), rs1_addr/rs2_addr
// with rs1_data_c/rs2_data_c, we/rd_addr/rd_data write port.
// x0 reads as zero and ignores writes; a same-cycle read sees the old value.
module rv32_regfile
  import rv32_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data_c,
  output logic [XLEN-1:0] rs2_data_c,
  input  logic            we,
  input  logic [4:0]      rd_addr,
  input  logic [XLEN-1:0] rd_data
);

  logic [XLEN-1:0] reg_file [0:RF_DEPTH-1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(RF_DEPTH); i++) reg_file[i] <= '0;
    end else if (we && (rd_addr != 5'd0)) begin
      reg_file[rd_addr] <= rd_data;
    end
  end

  assign rs1_data_c = (rs1_addr == 5'd0) ? '0 : reg_file[rs1_addr];
  assign rs2_data_c = (rs2_addr == 5'd0) ? '0 : reg_file[rs2_addr];

endmodule

// File: rtl/rv32_data_path.sv
// Single-cycle RV32I-subset core: PC, instruction ROM, decode, register
// file, ALU, data RAM and writeback, one instruction per clock.
// Ports: clk, rst (sync active-low; restarts at PC 0 and clears registers,
// data RAM keeps its contents). Unsupported opcodes execute as NOPs.
module rv32_data_path
  import rv32_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 64,
  parameter int unsigned DMEM_DEPTH = 32,
  parameter string       IMEM_FILE  = "program.hex",
  parameter string       DMEM_FILE  = "data.hex"
) (
  input logic clk,
  input logic rst
);

  localparam int unsigned IMEM_AW = $clog2(IMEM_DEPTH);

  logic [XLEN-1:0] pc_current_r;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_target;
  logic [XLEN-1:0] imem [0:IMEM_DEPTH-1];
  logic [XLEN-1:0] instr;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            alt;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic [4:0]      rd_addr;
  ctrl_t           ctrl;

  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_result;
  logic [4:0]      shamt;
  logic            br_taken;
  logic [XLEN-1:0] wb_data;

  rv32_data_path_if dbus ();

  // Power-on program image: all-NOP ROM
  initial begin
    for (int i = 0; i < int'(IMEM_DEPTH); i++) imem[i] = '0;
  end

  assign instr    = imem[pc_current_r[IMEM_AW+1:2]];
  assign opcode   = instr[6:0];
  assign rd_addr  = instr[11:7];
  assign funct3   = instr[14:12];
  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];
  assign alt      = (instr[31:25] == F7_ALT);

  // Main decoder
  always_comb begin
    ctrl = CTRL_NOP;
    case (opcode)
      OP: begin
        ctrl.reg_we = 1'b1;
        ctrl.alu_op = alu_op_decode(funct3, alt, 1'b1);
      end
      OP_IMM: begin
        ctrl.reg_we    = 1'b1;
        ctrl.alu_b_imm = 1'b1;
        ctrl.alu_op    = alu_op_decode(funct3, alt, 1'b0);
      end
      LOAD: begin
        if (funct3 == F3_WORD) begin
          ctrl.reg_we    = 1'b1;
          ctrl.alu_b_imm = 1'b1;
          ctrl.wb_sel    = WB_MEM;
        end
      end
      STORE: begin
        if (funct3 == F3_WORD) begin
          ctrl.mem_we    = 1'b1;
          ctrl.alu_b_imm = 1'b1;
          ctrl.imm_sel   = IMM_S;
        end
      end
      BRANCH: begin
        ctrl.branch  = 1'b1;
        ctrl.imm_sel = IMM_B;
      end
      JAL: begin
        ctrl.reg_we  = 1'b1;
        ctrl.jal     = 1'b1;
        ctrl.imm_sel = IMM_J;
        ctrl.wb_sel  = WB_PC4;
      end
      JALR: begin
        ctrl.reg_we    = 1'b1;
        ctrl.jalr      = 1'b1;
        ctrl.alu_b_imm = 1'b1;
        ctrl.wb_sel    = WB_PC4;
      end
      LUI: begin
        ctrl.reg_we  = 1'b1;
        ctrl.imm_sel = IMM_U;
        ctrl.wb_sel  = WB_IMM;
      end
      AUIPC: begin
        ctrl.reg_we    = 1'b1;
        ctrl.alu_a_pc  = 1'b1;
        ctrl.alu_b_imm = 1'b1;
        ctrl.imm_sel   = IMM_U;
      end
      default: ;
    endcase
  end

  // Immediate generator
  always_comb begin
    imm = {{20{instr[31]}}, instr[31:20]};
    case (ctrl.imm_sel)
      IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                    instr[11:8], 1'b0};
      IMM_U: imm = {instr[31:12], 12'h000};
      IMM_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                    instr[30:21], 1'b0};
      default: ;
    endcase
  end

  rv32_regfile rf0 (
    .clk        (clk),
    .rst        (rst),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1_data_c (rs1_data),
    .rs2_data_c (rs2_data),
    .we         (ctrl.reg_we),
    .rd_addr    (rd_addr),
    .rd_data    (wb_data)
  );

  // ALU
  assign alu_a = ctrl.alu_a_pc  ? pc_current_r : rs1_data;
  assign alu_b = ctrl.alu_b_imm ? imm          : rs2_data;
  assign shamt = alu_b[4:0];

  always_comb begin
    alu_result = alu_a + alu_b;
    case (ctrl.alu_op)
      ALU_ADD:  alu_result = alu_a + alu_b;
      ALU_SUB:  alu_result = alu_a - alu_b;
      ALU_AND:  alu_result = alu_a & alu_b;
      ALU_OR:   alu_result = alu_a | alu_b;
      ALU_XOR:  alu_result = alu_a ^ alu_b;
      ALU_SLT:  alu_result = XLEN'($signed(alu_a) < $signed(alu_b));
      ALU_SLTU: alu_result = XLEN'(alu_a < alu_b);
      ALU_SLL:  alu_result = alu_a << shamt;
      ALU_SRL:  alu_result = alu_a >> shamt;
      ALU_SRA:  alu_result = XLEN'($signed(alu_a) >>> shamt);
      default: ;
    endcase
  end

  // Branch condition from the register operands, independent of the ALU
  always_comb begin
    br_taken = 1'b0;
    if (ctrl.branch) begin
      case (funct3)
        F3_BEQ:  br_taken = (rs1_data == rs2_data);
        F3_BNE:  br_taken = (rs1_data != rs2_data);
        F3_BLT:  br_taken = ($signed(rs1_data) < $signed(rs2_data));
        F3_BGE:  br_taken = ($signed(rs1_data) >= $signed(rs2_data));
        default: br_taken = 1'b0;
      endcase
    end
  end

  // Data RAM; stores are suppressed while reset is asserted
  assign dbus.addr  = alu_result;
  assign dbus.wdata = rs2_data;
  assign dbus.we    = ctrl.mem_we && rst;

  rv32_dmem #(
    .DEPTH     (DMEM_DEPTH),
    .INIT_FILE (DMEM_FILE)
  ) dm0 (
    .clk (clk),
    .bus (dbus)
  );

  // Writeback mux
  always_comb begin
    wb_data = alu_result;
    case (ctrl.wb_sel)
      WB_ALU: wb_data = alu_result;
      WB_MEM: wb_data = dbus.rdata;
      WB_PC4: wb_data = pc_plus4;
      WB_IMM: wb_data = imm;
      default: ;
    endcase
  end

  // Next PC; imm already holds the B or J offset for branch/jal
  assign pc_plus4  = pc_current_r + 32'd4;
  assign pc_target = pc_current_r + imm;

  always_comb begin
    pc_next = pc_plus4;
    if (ctrl.jalr)                 pc_next = alu_result & ~32'd1;
    else if (ctrl.jal || br_taken) pc_next = pc_target;
  end

  always_ff @(posedge clk) begin
    if (!rst) pc_current_r <= '0;
    else      pc_current_r <= pc_next;
  end

endmodule

// File: tb/tb_rv32_data_path.sv
// Directed bench for rv32_data_path: loads a hand-assembled program into the
// instruction ROM, traces the PC through branches and jumps, checks register
// and RAM results against hand-computed values, and exercises reset both at
// start-up and in the middle of a run.
module tb_rv32_data_path;

  localparam logic [6:0] T_OP     = 7'b0110011;
  localparam logic [6:0] T_OP_IMM = 7'b0010011;
  localparam logic [6:0] T_LOAD   = 7'b0000011;
  localparam logic [6:0] T_JALR   = 7'b1100111;
  localparam logic [6:0] T_LUI    = 7'b0110111;
  localparam logic [6:0] T_AUIPC  = 7'b0010111;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  logic [31:0] prog   [0:63];
  logic [31:0] exp_rf [0:31];
  logic [31:0] exp_pc [0:30] = '{
    32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h20,
    32'h30, 32'h24, 32'h34, 32'h38, 32'h3C, 32'h40, 32'h44, 32'h48,
    32'h4C, 32'h50, 32'h54, 32'h58, 32'h5C, 32'h60, 32'h64, 32'h68,
    32'h6C, 32'h70, 32'h78, 32'h7C, 32'h80, 32'h84, 32'h84
  };

  rv32_data_path #(
    .IMEM_DEPTH (64),
    .DMEM_DEPTH (32),
    .IMEM_FILE  (""),
    .DMEM_FILE  ("")
  ) dut (
    .clk (clk),
    .rst (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, T_OP};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic build_program();
    for (int i = 0; i < 64; i++) prog[i] = 32'h0;
    prog[0]  = enc_i(12'd5,   5'd0,  3'b000, 5'd5,  T_OP_IMM);  // addi x5,x0,5
    prog[1]  = enc_i(12'hFFD, 5'd0,  3'b000, 5'd6,  T_OP_IMM);  // addi x6,x0,-3
    prog[2]  = enc_r(7'h00, 5'd6, 5'd5, 3'b000, 5'd18);         // add x18,x5,x6
    prog[3]  = enc_r(7'h20, 5'd6, 5'd5, 3'b000, 5'd19);         // sub x19,x5,x6
    prog[4]  = enc_r(7'h00, 5'd5, 5'd6, 3'b010, 5'd7);          // slt x7,x6,x5
    prog[5]  = enc_i(12'd7,   5'd0,  3'b000, 5'd0,  T_OP_IMM);  // addi x0,x0,7
    prog[6]  = enc_b(13'd8, 5'd5, 5'd5, 3'b000);                // beq x5,x5,+8
    prog[7]  = enc_i(12'd99,  5'd0,  3'b000, 5'd8,  T_OP_IMM);  // skipped
    prog[8]  = enc_j(21'd16, 5'd1);                             // jal x1,+16
    prog[9]  = enc_j(21'd16, 5'd0);                             // jal x0,+16
    prog[10] = enc_i(12'd1,   5'd0,  3'b000, 5'd9,  T_OP_IMM);  // skipped
    prog[11] = enc_i(12'd2,   5'd0,  3'b000, 5'd9,  T_OP_IMM);  // skipped
    prog[12] = enc_i(12'd0,   5'd1,  3'b000, 5'd0,  T_JALR);    // jalr x0,0(x1)
    prog[13] = enc_b(13'd8, 5'd5, 5'd5, 3'b001);                // bne x5,x5,+8
    prog[14] = enc_u(20'h00001, 5'd20, T_LUI);                  // lui x20,1
    prog[15] = enc_i(12'h234, 5'd20, 3'b000, 5'd20, T_OP_IMM);  // addi x20,x20,0x234
    prog[16] = enc_s(12'd48,  5'd20, 5'd0);                     // sw x20,48(x0)
    prog[17] = enc_i(12'd48,  5'd0,  3'b010, 5'd21, T_LOAD);    // lw x21,48(x0)
    prog[18] = enc_s(12'h080, 5'd5,  5'd0);                     // sw x5,0x80(x0)
    prog[19] = enc_s(12'd4,   5'd6,  5'd0);                     // sw x6,4(x0)
    prog[20] = enc_s(12'd8,   5'd18, 5'd0);                     // sw x18,8(x0)
    prog[21] = enc_s(12'd12,  5'd19, 5'd0);                     // sw x19,12(x0)
    prog[22] = enc_s(12'd16,  5'd7,  5'd0);                     // sw x7,16(x0)
    prog[23] = enc_r(7'h00, 5'd6, 5'd5, 3'b011, 5'd22);         // sltu x22,x5,x6
    prog[24] = enc_r(7'h20, 5'd7, 5'd6, 3'b101, 5'd23);         // sra x23,x6,x7
    prog[25] = enc_r(7'h00, 5'd7, 5'd6, 3'b101, 5'd24);         // srl x24,x6,x7
    prog[26] = enc_r(7'h00, 5'd6, 5'd5, 3'b100, 5'd25);         // xor x25,x5,x6
    prog[27] = enc_u(20'h00002, 5'd26, T_AUIPC);                // auipc x26,2
    prog[28] = enc_b(13'd8, 5'd5, 5'd6, 3'b100);                // blt x6,x5,+8
    prog[29] = enc_i(12'd1,   5'd0,  3'b000, 5'd27, T_OP_IMM);  // skipped
    prog[30] = enc_b(13'd8, 5'd5, 5'd6, 3'b101);                // bge x6,x5,+8
    prog[31] = enc_i(12'd7,   5'd0,  3'b000, 5'd28, T_OP_IMM);  // addi x28,x0,7
    prog[32] = enc_i(12'd4,   5'd5,  3'b001, 5'd29, T_OP_IMM);  // slli x29,x5,4
    prog[33] = enc_j(21'd0, 5'd0);                              // jal x0,0
    for (int i = 0; i < 64; i++) dut.imem[i] = prog[i];

    for (int i = 0; i < 32; i++) exp_rf[i] = 32'h0;
    exp_rf[1]  = 32'h0000_0024;
    exp_rf[5]  = 32'h0000_0005;
    exp_rf[6]  = 32'hFFFF_FFFD;
    exp_rf[7]  = 32'h0000_0001;
    exp_rf[18] = 32'h0000_0002;
    exp_rf[19] = 32'h0000_0008;
    exp_rf[20] = 32'h0000_1234;
    exp_rf[21] = 32'h0000_1234;
    exp_rf[22] = 32'h0000_0001;
    exp_rf[23] = 32'hFFFF_FFFE;
    exp_rf[24] = 32'h7FFF_FFFE;
    exp_rf[25] = 32'hFFFF_FFF8;
    exp_rf[26] = 32'h0000_206C;
    exp_rf[28] = 32'h0000_0007;
    exp_rf[29] = 32'h0000_0050;
  endtask

  task automatic check_ram();
    check("ram0_wrap", dut.dm0.ram[0],  32'h0000_0005);
    check("ram1",      dut.dm0.ram[1],  32'hFFFF_FFFD);
    check("ram2",      dut.dm0.ram[2],  32'h0000_0002);
    check("ram3",      dut.dm0.ram[3],  32'h0000_0008);
    check("ram4",      dut.dm0.ram[4],  32'h0000_0001);
    check("ram12",     dut.dm0.ram[12], 32'h0000_1234);
  endtask

  task automatic check_final(input string tag);
    for (int i = 0; i < 32; i++)
      check($sformatf("%s_x%0d", tag, i), dut.rf0.reg_file[i], exp_rf[i]);
    check_ram();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pc"}, dut.pc_current_r, 32'h0);
    for (int i = 0; i < 32; i++)
      check($sformatf("%s_x%0d", tag, i), dut.rf0.reg_file[i], 32'h0);
  endtask

  task automatic run_until_pc(input logic [31:0] target, input int budget);
    int n;
    n = 0;
    while (dut.pc_current_r !== target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("pc_reach", dut.pc_current_r, target);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b0;

    @(negedge clk);
    build_program();
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_reset_state("rst");
    rst = 1'b1;

    // PC trace covers sequential flow, beq/blt taken, bne/bge fall-through,
    // jal to 0x30 and jalr back to 0x24
    for (int k = 0; k < 31; k++) begin
      check($sformatf("pc_trace%0d", k), dut.pc_current_r, exp_pc[k]);
      if (k == 8)  check("jal_link", dut.rf0.reg_file[1], 32'h24);
      if (k == 6)  check("x0_keep",  dut.rf0.reg_file[0], 32'h0);
      if (k < 30) @(negedge clk);
    end
    check_final("run1");

    // Reset after RAM is populated: registers clear, RAM survives
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("mid1");
    check_ram();
    rst = 1'b1;

    // Second reset part-way through the program
    run_until_pc(32'h60, 100);
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("mid2");
    check_ram();
    rst = 1'b1;

    run_until_pc(32'h84, 100);
    check_final("run2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
